// File: rtl/follower_pkg.sv
// Shared types and constants for the Follower's serial-input decoders.
package follower_pkg;

  localparam int         BC_CNT_W   = 22;
  localparam int         BC_BITS    = 8;
  localparam logic [7:0] BC_ID_MASK = 8'hC0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAL       = 2'd1,
    WAIT_FALL = 2'd2,
    SAMPLE    = 2'd3
  } bc_state_t;

endpackage

// File: rtl/sync_fall_det.sv
// Two-flop synchronizer for an idle-high async line plus a falling-edge strobe.
module sync_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic synced,
  output logic fall
);

  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], din};
  end

  // Reset to all-ones so an idle-high line never yields a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) sh_q <= 3'b111;
    else     sh_q <= sh_d;
  end

  assign synced = sh_q[1];
  assign fall   = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/barcode_rx.sv
// Barcode station-tag receiver: calibrates on the first low pulse, then samples
// each data bit at the calibrated delay after its falling edge.
module barcode_rx
  import follower_pkg::*;
#(
  parameter int               CNT_W   = BC_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       frame_err,
  output logic       busy
);

  logic synced, fall;

  sync_fall_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (BC),
    .synced (synced),
    .fall   (fall)
  );

  bc_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cal_q, cal_d, wdog_q, wdog_d;
  logic [7:0]       shift_q, shift_d, id_q, id_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             id_vld_q, id_vld_d, frame_err_q, frame_err_d;
  logic [CNT_W-1:0] cnt_inc, wdog_inc;
  logic [7:0]       new_shift;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cal_d       = cal_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    id_d        = id_q;
    id_vld_d    = clr_ID_vld ? 1'b0 : id_vld_q;
    frame_err_d = 1'b0;
    cnt_inc     = (&cnt_q)  ? cnt_q  : cnt_q + 1'b1;
    wdog_inc    = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
    new_shift   = {shift_q[6:0], synced};

    // Watchdog measures cycles since the most recent falling edge.
    if (fall)                 wdog_d = CNT_W'(1);
    else if (state_q == IDLE) wdog_d = '0;
    else                      wdog_d = wdog_inc;

    if (state_q != IDLE && wdog_q >= TIMEOUT) begin
      state_d     = IDLE;
      cnt_d       = '0;
      bit_cnt_d   = '0;
      frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_d   = CAL;
            cnt_d     = CNT_W'(1);
            bit_cnt_d = '0;
          end
        end
        CAL: begin
          if (!synced) begin
            cnt_d = cnt_inc;
          end else begin
            cal_d   = cnt_q;
            cnt_d   = '0;
            state_d = WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (fall) begin
            state_d = SAMPLE;
            cnt_d   = CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (cnt_q == cal_q) begin
            shift_d   = new_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(BC_BITS - 1)) begin
              state_d = IDLE;
              id_d    = new_shift;
              // A valid ID sets the flag even against a coincident clear.
              if ((new_shift & BC_ID_MASK) == 8'h00) id_vld_d    = 1'b1;
              else                                   frame_err_d = 1'b1;
            end else begin
              state_d = WAIT_FALL;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cal_q       <= '0;
      wdog_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      id_q        <= '0;
      id_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cal_q       <= cal_d;
      wdog_q      <= wdog_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      id_q        <= id_d;
      id_vld_q    <= id_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ID        = id_q;
  assign ID_vld    = id_vld_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/barcode_rx.md
Name: barcode_rx

Overview:
- Decodes the serial barcode stream `BC` that the track-side station tag (barcode mimic) produces as the Follower passes over it.
- Recovers the 8-bit station ID, qualifies it, and presents it with a sticky valid flag to the Follower's command/steering control.
- Sits directly downstream of the barcode source and upstream of the command processor that compares the ID against the commanded destination.

Parameters:
CNT_W, 22, width of the pulse-timing counter; matches the barcode period field width.
TIMEOUT, 22'h3F_FFFF, cycles allowed between falling edges inside a frame before the frame is aborted.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-high reset
BC  input  1  raw barcode line; idles high; asynchronous to clk
clr_ID_vld  input  1  one-cycle pulse from consumer; clears ID_vld
ID  output  8  last decoded station ID, MSB first on the line
ID_vld  output  1  high when ID holds a frame with ID[7:6]==2'b00
frame_err  output  1  one-cycle pulse on timeout abort or on a frame with ID[7:6]!=0
busy  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Input conditioning:
  - `BC` passes through 2 flops (metastability) plus a third flop for edge detection.
  - `fall` = prev & ~cur, asserted 3 cycles after the line edge.
  - All timing below is relative to `fall`.
- Frame format:
  - Frame = 1 calibration bit, then 8 data bits, MSB first.
  - Every bit starts with a falling edge.
  - Calibration bit is low for T/2.
  - Data '1' is low for T/4; data '0' is low for 3T/4.
  - Line returns high for the rest of each bit period.
- Reset: IDLE; cnt=0; cal=0; shift=0; bit_cnt=0; ID=0; ID_vld=0; frame_err=0; busy=0.
- FSM states IDLE, CAL, WAIT_FALL, SAMPLE:
  - IDLE: on `fall` -> CAL, cnt<=1.
  - CAL: cnt increments each cycle while the synced line is low. On the synced line returning high: cal<=cnt, cnt<=0 -> WAIT_FALL.
  - WAIT_FALL: on `fall` -> SAMPLE, cnt<=1.
  - SAMPLE: cnt increments; when cnt==cal, shift<={shift[6:0], synced line}, bit_cnt++. If bit_cnt was 7 -> frame complete, IDLE; else -> WAIT_FALL.
  - A line low at the sample instant decodes as 0; high decodes as 1.
- Frame complete:
  - ID<=new shift value.
  - If new [7:6]==2'b00, ID_vld<=1 on the same edge.
  - Else ID_vld unchanged and frame_err pulses for 1 cycle.
  - ID updates even on a bad frame; consumers qualify ID only by ID_vld.
- Latency: ID/ID_vld update exactly 1 clk after the 8th sample point, which is cal cycles after the 8th synced `fall`.
- Timeout: in CAL, WAIT_FALL or SAMPLE, a watchdog counts cycles since the last `fall`. On reaching TIMEOUT: -> IDLE, frame_err pulse, ID/ID_vld untouched.
- Counters saturate at all-ones (no wrap). A saturated cal is still used.
- Simultaneous frame-complete with valid ID and clr_ID_vld: set wins, ID_vld=1.
- clr_ID_vld in any other cycle: ID_vld<=0 next edge.
- clr_ID_vld does not affect busy or an in-progress frame.
- rst mid-frame: every register returns to its reset value on the next clk edge. A partial frame is discarded. The remainder of that frame's bits will look like a new frame and be rejected by timeout/format.
- busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared package `follower_pkg`:
  - `bc_state_t` enum {IDLE, CAL, WAIT_FALL, SAMPLE}
  - localparams BC_BITS=8 and BC_ID_MASK=8'hC0
  - CNT_W default
- One natural sub-module, `sync_fall_det`: 2-flop synchronizer plus falling-edge detect, outputs `synced` and `fall`, with clk/rst. It is reusable for the OK2Move and RX inputs.

Test Plan:
- Mimic period 22'h1000, send ID 8'h15 -> cal captured ≈2048 (±3); ID=8'h15, ID_vld=1, frame_err=0; busy high throughout the frame, low after.
- Send 8'h3F, then pulse clr_ID_vld -> ID=8'h3F, ID_vld=1; ID_vld=0 one cycle after the clear; ID still 8'h3F.
- Send 8'hC5 -> ID=8'hC5, ID_vld stays 0, frame_err single-cycle pulse at frame end.
- Drive only the calibration pulse (2048 low), then hold BC high with TIMEOUT overridden to 22'h4000 -> frame_err pulse 16384 cycles after the last fall; state IDLE; ID unchanged.
- Assert rst for 1 cycle after bit 3 of an 8'h2A frame -> all outputs 0 next edge. The next full frame of 8'h0B decodes correctly with ID_vld=1.
- clr_ID_vld coincident with completion of a valid frame 8'h01 -> ID_vld=1 after that edge.
